// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder/subtractor.
// Stage/level counts are computed here so the parent and any wrapper agree on latency.
package ksa_pkg;

    // One bit position of the prefix network: group generate and group propagate.
    typedef struct packed {
        logic g;
        logic p;
    } ksa_gp_t;

    function automatic int ksa_levels(input int width);
        return (width <= 1) ? 0 : $clog2(width);
    endfunction

    function automatic int ksa_stages(input int width, input int reg_every);
        int lv;
        lv = ksa_levels(width);
        return 1 + (lv + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level: combines each position with the one DIST below.
// Positions below DIST already hold their final group terms and pass straight through.
module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  ksa_gp_t [WIDTH-1:0] i_gp,
    output ksa_gp_t [WIDTH-1:0] o_gp
);

    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if (j >= DIST) begin : g_comb
            assign o_gp[j].g = i_gp[j].g | (i_gp[j].p & i_gp[j-DIST].g);
            assign o_gp[j].p = i_gp[j].p & i_gp[j-DIST].p;
        end else begin : g_pass
            assign o_gp[j] = i_gp[j];
        end
    end

endmodule

// File: rtl/ksa_pipe_addsub.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in, signed overflow and valid/ready flow.
// A register bank sits after the input stage and after every REG_EVERY prefix levels.
module ksa_pipe_addsub
    import ksa_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    localparam int LEVELS = ksa_levels(WIDTH);
    localparam int STAGES = ksa_stages(WIDTH, REG_EVERY);
    localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LVL_N  = (LEVELS > 0) ? LEVELS : 1;

    // Handshake: input transfers on in_valid & in_ready, output on out_valid & out_ready.
    // One global enable moves the whole pipe; it stalls only when a result is held unread.
    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    logic [WIDTH-1:0]    w_bx;
    logic [WIDTH-1:0]    w_p0;
    logic                w_c0;
    ksa_gp_t [WIDTH-1:0] w_front;

    always_comb begin
        w_bx = sub ? ~b : b;
        w_c0 = sub | cin;
        w_p0 = a ^ w_bx;
        for (int j = 0; j < WIDTH; j++) begin
            w_front[j].g = a[j] & w_bx[j];
            w_front[j].p = w_p0[j];
        end
        // Carry-in enters as a generate at position -1, absorbed into bit 0.
        w_front[0].g = (a[0] & w_bx[0]) | (w_p0[0] & w_c0);
    end

    ksa_gp_t [WIDTH-1:0] r_gp  [NREG];
    logic    [WIDTH-1:0] r_p0  [NREG];
    logic                r_c0  [NREG];
    logic    [TAG_W-1:0] r_tag [NREG];

    ksa_gp_t [WIDTH-1:0] w_lin [1:LVL_N];
    ksa_gp_t [WIDTH-1:0] w_lvl [1:LVL_N];

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        if (((k - 1) % REG_EVERY) == 0) begin : g_from_reg
            assign w_lin[k] = r_gp[(k - 1) / REG_EVERY];
        end else begin : g_from_comb
            assign w_lin[k] = w_lvl[k-1];
        end

        ksa_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (k - 1))
        ) u_level (
            .i_gp (w_lin[k]),
            .o_gp (w_lvl[k])
        );
    end

    // Data banks carry no reset; only the valid bits decide what is meaningful.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_gp[0]  <= w_front;
            r_p0[0]  <= w_p0;
            r_c0[0]  <= w_c0;
            r_tag[0] <= tag;
            for (int s = 1; s < STAGES - 1; s++) begin
                r_gp[s]  <= w_lvl[s * REG_EVERY];
                r_p0[s]  <= r_p0[s-1];
                r_c0[s]  <= r_c0[s-1];
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    logic [WIDTH-1:0] w_gf;
    logic [WIDTH-1:0] w_fp0;
    logic             w_fc0;
    logic [TAG_W-1:0] w_ftag;

    if (STAGES == 1) begin : g_src_front
        for (genvar j = 0; j < WIDTH; j++) begin : g_gf
            assign w_gf[j] = w_front[j].g;
        end
        assign w_fp0  = w_p0;
        assign w_fc0  = w_c0;
        assign w_ftag = tag;
    end else begin : g_src_pipe
        for (genvar j = 0; j < WIDTH; j++) begin : g_gf
            assign w_gf[j] = w_lvl[LEVELS][j].g;
        end
        assign w_fp0  = r_p0[STAGES-2];
        assign w_fc0  = r_c0[STAGES-2];
        assign w_ftag = r_tag[STAGES-2];
    end

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_c_msb;

    // Gf[j] is the carry out of bit j, so each sum bit takes the carry from the bit below.
    always_comb begin
        w_sum   = '0;
        w_carry = w_fc0;
        w_c_msb = w_fc0;
        for (int j = 0; j < WIDTH; j++) begin
            w_sum[j] = w_fp0[j] ^ w_carry;
            w_c_msb  = w_carry;
            w_carry  = w_gf[j];
        end
    end

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic [TAG_W-1:0]  r_tag_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v       <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_tag_out <= '0;
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                r_v[s] <= r_v[s-1];
            end
            r_sum     <= w_sum;
            r_cout    <= w_carry;
            r_ovf     <= w_carry ^ w_c_msb;
            r_tag_out <= w_ftag;
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_ksa_pipe_addsub.sv
// Bench for ksa_pipe_addsub: 32-bit pipe under random backpressure plus three small variants.
// Expected results come from plain wide arithmetic on the operands.
module tb_ksa_pipe_addsub;

    localparam int W  = 32;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;
    logic [TW-1:0] tag, tag_out;

    ksa_pipe_addsub #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .tag_out(tag_out)
    );

    logic        sw_ready;
    logic        s7_iv, s7_ir, s7_cin, s7_sub, s7_ov, s7_co, s7_of;
    logic [6:0]  s7_a, s7_b, s7_sum;
    logic [3:0]  s7_tag, s7_tago;
    logic        s1_iv, s1_ir, s1_cin, s1_sub, s1_ov, s1_co, s1_of;
    logic [0:0]  s1_a, s1_b, s1_sum;
    logic [3:0]  s1_tag, s1_tago;
    logic        s33_iv, s33_ir, s33_cin, s33_sub, s33_ov, s33_co, s33_of;
    logic [32:0] s33_a, s33_b, s33_sum;
    logic [3:0]  s33_tag, s33_tago;

    ksa_pipe_addsub #(.WIDTH(7), .REG_EVERY(2), .TAG_W(4)) u_w7 (
        .clk(clk), .rst_n(rst_n), .in_valid(s7_iv), .in_ready(s7_ir),
        .a(s7_a), .b(s7_b), .cin(s7_cin), .sub(s7_sub), .tag(s7_tag),
        .out_valid(s7_ov), .out_ready(sw_ready),
        .sum(s7_sum), .cout(s7_co), .ovf(s7_of), .tag_out(s7_tago)
    );

    ksa_pipe_addsub #(.WIDTH(1), .REG_EVERY(1), .TAG_W(4)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_iv), .in_ready(s1_ir),
        .a(s1_a), .b(s1_b), .cin(s1_cin), .sub(s1_sub), .tag(s1_tag),
        .out_valid(s1_ov), .out_ready(sw_ready),
        .sum(s1_sum), .cout(s1_co), .ovf(s1_of), .tag_out(s1_tago)
    );

    ksa_pipe_addsub #(.WIDTH(33), .REG_EVERY(3), .TAG_W(4)) u_w33 (
        .clk(clk), .rst_n(rst_n), .in_valid(s33_iv), .in_ready(s33_ir),
        .a(s33_a), .b(s33_b), .cin(s33_cin), .sub(s33_sub), .tag(s33_tag),
        .out_valid(s33_ov), .out_ready(sw_ready),
        .sum(s33_sum), .cout(s33_co), .ovf(s33_of), .tag_out(s33_tago)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [TW+W+1:0] exp_q[$];
    logic [70:0]     q7[$], q1[$], q33[$];
    logic            hold_pending = 1'b0;
    logic [TW+W+1:0] hold_val;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit operation, sum zero-extended to 64 bits.
    function automatic logic [65:0] ref_addsub(input int w, input logic [63:0] fa, input logic [63:0] fb,
                                               input logic fcin, input logic fsub);
        logic [64:0] mask, bx, full;
        logic [63:0] s;
        logic        co, of;
        mask = (65'd1 << w) - 65'd1;
        bx   = (fsub ? ~{1'b0, fb} : {1'b0, fb}) & mask;
        full = {1'b0, fa} + bx + {64'd0, (fsub | fcin)};
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        of   = (fa[w-1] == bx[w-1]) && (s[w-1] != fa[w-1]);
        return {of, co, s};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard for the 32-bit pipe: push on input transfer, pop on output transfer.
    always @(negedge clk) begin
        logic [65:0] r;
        if (rst_n) begin
            chk("in_ready_rule", in_ready, (!out_valid) || out_ready);
            if (hold_pending) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", {tag_out, ovf, cout, sum}, hold_val);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out got=%0h exp=none", sum);
                end else begin
                    chk("result", {tag_out, ovf, cout, sum}, exp_q.pop_front());
                end
            end
            hold_pending = out_valid && !out_ready;
            hold_val     = {tag_out, ovf, cout, sum};
            if (in_valid && in_ready) begin
                r = ref_addsub(W, 64'(a), 64'(b), cin, sub);
                exp_q.push_back({tag, r[65], r[64], r[31:0]});
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic directed(input logic [31:0] ta, input logic [31:0] tb_op, input logic tcin,
                            input logic tsub, input logic [3:0] ttag, input logic [31:0] es,
                            input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; a = ta; b = tb_op; cin = tcin; sub = tsub; tag = ttag; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("dir_latency", lat, 6);
        chk("dir_sum", sum, es);
        chk("dir_cout", cout, ec);
        chk("dir_ovf", ovf, eo);
        chk("dir_tag", tag_out, ttag);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_pipe(input string nm, ref logic [70:0] q[$], input int s, input logic [70:0] now_in,
                            input logic ir, input logic ov, input logic [3:0] tg, input logic of,
                            input logic co, input logic [63:0] sm);
        logic [70:0] e;
        chk({nm, "_in_ready"}, ir, 1'b1);
        if (q.size() == s) begin
            e = q.pop_front();
            chk({nm, "_valid"}, ov, e[70]);
            if (e[70]) chk({nm, "_result"}, {tg, of, co, sm}, e[69:0]);
        end
        q.push_back(now_in);
    endtask

    // Small variants run with out_ready tied high, so output at cycle t belongs to input at t-S.
    task automatic run_sweep(input int ncyc);
        logic [65:0] r;
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk); #1;
            s7_iv = ($urandom_range(0, 3) != 0);
            s7_a = 7'($urandom); s7_b = 7'($urandom);
            s7_cin = 1'($urandom_range(0, 1)); s7_sub = 1'($urandom_range(0, 1)); s7_tag = 4'($urandom);
            s1_iv = 1'b1;
            s1_a = t[0]; s1_b = t[1]; s1_cin = t[2]; s1_sub = t[3]; s1_tag = 4'(t);
            s33_iv = ($urandom_range(0, 3) != 0);
            s33_a = {1'($urandom_range(0, 1)), $urandom}; s33_b = {1'($urandom_range(0, 1)), $urandom};
            s33_cin = 1'($urandom_range(0, 1)); s33_sub = 1'($urandom_range(0, 1)); s33_tag = 4'($urandom);
            @(negedge clk);
            r = ref_addsub(7, 64'(s7_a), 64'(s7_b), s7_cin, s7_sub);
            chk_pipe("w7", q7, 3, {s7_iv, s7_tag, r}, s7_ir, s7_ov, s7_tago, s7_of, s7_co, 64'(s7_sum));
            r = ref_addsub(1, 64'(s1_a), 64'(s1_b), s1_cin, s1_sub);
            chk_pipe("w1", q1, 1, {s1_iv, s1_tag, r}, s1_ir, s1_ov, s1_tago, s1_of, s1_co, 64'(s1_sum));
            r = ref_addsub(33, 64'(s33_a), 64'(s33_b), s33_cin, s33_sub);
            chk_pipe("w33", q33, 3, {s33_iv, s33_tag, r}, s33_ir, s33_ov, s33_tago, s33_of, s33_co, 64'(s33_sum));
        end
        @(posedge clk); #1;
        s7_iv = 1'b0; s1_iv = 1'b0; s33_iv = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, n_acc, cnt;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0;
        out_ready = 1'b0; sw_ready = 1'b1;
        s7_iv = 1'b0; s7_a = '0; s7_b = '0; s7_cin = 1'b0; s7_sub = 1'b0; s7_tag = '0;
        s1_iv = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_sub = 1'b0; s1_tag = '0;
        s33_iv = 1'b0; s33_a = '0; s33_b = '0; s33_cin = 1'b0; s33_sub = 1'b0; s33_tag = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_tag_out", tag_out, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        directed(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h3, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h5, 32'h8000_0000, 1'b0, 1'b1);
        directed(32'h5,         32'h7, 1'b0, 1'b1, 4'h9, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed(32'h5,         32'h7, 1'b1, 1'b1, 4'hA, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed(32'h0,         32'h0, 1'b1, 1'b0, 4'hB, 32'h0000_0001, 1'b0, 1'b0);
        directed(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'hC, 32'h0000_0000, 1'b1, 1'b1);
        directed(32'h7,         32'h7, 1'b0, 1'b1, 4'hD, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        sent = 0;
        acc  = 1'b0;
        while (sent < 100) begin
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                a = pick32(); b = pick32();
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                tag = sent[3:0];
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        n_acc = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1)); tag = 4'(i);
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) n_acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_fill", n_acc, 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid) break;
            cnt++;
        end
        chk("stall_release", cnt, n_acc);
        drain();

        run_sweep(200);

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 32'h1234_0000 + 32'(i); b = 32'h0000_1111;
            cin = 1'b0; sub = 1'b0; tag = 4'(i + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_sum", sum, 32'h0);
        chk("arst_cout", cout, 1'b0);
        chk("arst_ovf", ovf, 1'b0);
        chk("arst_tag_out", tag_out, 4'h0);
        chk("arst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("no_stale", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
